// File: rtl/rr_bus_arbiter_mux.sv
// rtl/rr_bus_arbiter_mux.sv - registered N-way bus mux with round-robin ownership arbiter
//
// Purpose: grants the shared bus to one requesting source at a time. The winner's data
// is registered onto bus_out every cycle. It keeps the bus until it releases it, drops
// its request, or reaches the MAXHOLD cycle cap.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   req          per-channel level request
//   data_in      channel i data at [i*W +: W]
//   release_bus  owner done; only looked at while the bus is owned
//   grant        registered one-hot grant, zero when idle
//   bus_out      registered bus value
//   valid        bus_out carries the granted channel's data
//   busy         bus currently owned
//   timeout      one-cycle pulse when ownership is ended by the MAXHOLD cap
module rr_bus_arbiter_mux #(
  parameter int N       = 8,
  parameter int W       = 16,
  parameter int MAXHOLD = 0,
  parameter int HOLD    = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] data_in,
  input  logic           release_bus,
  output logic [N-1:0]   grant,
  output logic [W-1:0]   bus_out,
  output logic           valid,
  output logic           busy,
  output logic           timeout
);

  localparam int PW = $clog2(N);
  localparam int CW = (MAXHOLD > 0) ? $clog2(MAXHOLD + 1) : 1;

  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] owner;
  logic [CW-1:0] cnt;

  logic [PW-1:0] pick;
  logic          pick_found;
  logic          end_rel;
  logic          end_drop;
  logic          end_cap;

  // (a + b) mod N for a < N and 0 <= b < N; N need not be a power of two.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= N) s = s - N;
    return PW'(s);
  endfunction

  function automatic logic [W-1:0] chan_data(input logic [PW-1:0] idx);
    return data_in[int'(idx)*W +: W];
  endfunction

  // Scan the offsets from the largest to the smallest. The last hit to be written is
  // the requester nearest rr_ptr, so no early exit is needed.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[wrap_add(rr_ptr, i)]) begin
        pick       = wrap_add(rr_ptr, i);
        pick_found = 1'b1;
      end
    end
  end

  assign end_rel  = release_bus;
  assign end_drop = !req[owner];
  assign end_cap  = (MAXHOLD != 0) && (cnt == CW'(MAXHOLD));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      owner   <= '0;
      cnt     <= '0;
      grant   <= '0;
      bus_out <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (HOLD == 0) bus_out <= '0;
          if (pick_found) begin
            state   <= OWNED;
            owner   <= pick;
            grant   <= {{(N-1){1'b0}}, 1'b1} << pick;
            bus_out <= chan_data(pick);
            valid   <= 1'b1;
            busy    <= 1'b1;
            cnt     <= CW'(1);
          end
        end
        OWNED: begin
          if (end_rel || end_drop || end_cap) begin
            state   <= IDLE;
            grant   <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            cnt     <= '0;
            rr_ptr  <= wrap_add(owner, 1);
            // A release or a dropped request outranks the cap, so only a pure cap expiry pulses.
            timeout <= end_cap && !end_rel && !end_drop;
            if (HOLD == 0) bus_out <= '0;
          end else begin
            bus_out <= chan_data(owner);
            // Without an end condition cnt < MAXHOLD here, so the count never passes the cap.
            if (MAXHOLD != 0) cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rr_bus_arbiter_mux.md
Name: rr_bus_arbiter_mux

Overview:
- Parametrised, registered N-way bus multiplexer with a built-in round-robin arbiter; successor to the combinational one-hot bus mux on the processor datapath.
- Multiple sources request the shared bus. The block grants one source at a time (one-hot grant), registers that source's data onto the bus, and holds ownership until release, request drop, or timeout.
- Sits between the register file/ALU/DIN sources and the shared bus.

Parameters:
- N, 8, number of source channels (2..16)
- W, 16, data width per channel
- MAXHOLD, 0, maximum consecutive owned cycles before forced release; 0 = unlimited
- HOLD, 1, 1 = bus_out keeps last value when idle; 0 = bus_out forced to zero when idle

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- req  in  N  per-channel bus request; level, held by requester while it wants the bus
- data_in  in  N*W  channel i data at bits [i*W+W-1 : i*W]
- release  in  1  owner done; sampled only in OWNED
- grant  out  N  registered one-hot grant; all zero when idle
- bus_out  out  W  registered bus value
- valid  out  1  bus_out carries the granted channel's data
- busy  out  1  state == OWNED
- timeout  out  1  one-cycle pulse on forced release by MAXHOLD

Behaviour:
- Reset: Reset is synchronous and active-high. On a Reset edge: state=IDLE, grant=0, bus_out=0, valid=0, busy=0, timeout=0, rr_ptr=0, hold counter=0. Reset overrides everything, including mid-ownership; no release pulse or timeout is produced.
- States: IDLE and OWNED only.
- IDLE, req==0: remain in IDLE, outputs stable. With HOLD=0, bus_out=0.
- IDLE, req!=0: select k = first index with req[k]=1, searching rr_ptr, rr_ptr+1, ... wrapping mod N. On the next edge: grant=onehot(k), bus_out=data_in[k], valid=1, busy=1, cnt=1, state=OWNED. Latency from request to grant is 1 cycle.
- OWNED, no end condition: each edge loads bus_out=data_in[k]. bus_out therefore lags data_in[k] by exactly one cycle. cnt increments and saturates at MAXHOLD.
- End conditions, evaluated in OWNED:
  - (a) release=1
  - (b) req[k]=0
  - (c) MAXHOLD!=0 and cnt==MAXHOLD
- On any end condition, the next edge sets: grant=0, valid=0, busy=0, state=IDLE, rr_ptr=(k+1) mod N, cnt=0. bus_out holds its value (HOLD=1) or goes to 0 (HOLD=0).
- timeout=1 for that single cycle only when (c) fires and neither (a) nor (b) is true.
- Simultaneous conditions: (a)/(b) take priority over (c), so timeout=0.
- Re-arbitration: at least one IDLE cycle always separates two grants. Requests arriving during OWNED wait; they are not pre-empted.
- Wrap-around: the rr_ptr search wraps from N-1 to 0. A sole requester is re-granted after its idle gap.
- Invariants: grant is always zero or one-hot. valid==busy. Grant changes only on edges. Other channels' req changes during OWNED have no effect.
- Width rules: cnt width = clog2(MAXHOLD+1), minimum 1. rr_ptr width = clog2(N).

Test Plan (N=4, W=8, HOLD=1 unless stated):
- Reset, then req=0 for 5 cycles -> grant=0000, bus_out=0x00, valid=0, busy=0 throughout.
- req=0100, data_in[2]=0xA5, release=0 -> one cycle later grant=0100, bus_out=0xA5, valid=1. Change data_in[2] to 0x3C -> bus_out=0x3C one cycle later. Pulse release -> next cycle grant=0000, valid=0, bus_out stays 0x3C.
- req=1111 held, release pulsed once per ownership -> grant sequence 0001, 0010, 0100, 1000, 0001, each separated by exactly one idle cycle. This covers wrap-around.
- MAXHOLD=3, req=0010 held, release=0 -> grant high for exactly 3 cycles. timeout=1 on the cycle grant drops. Re-grant to 0010 after one idle cycle.
- MAXHOLD=3, release=1 on the 3rd owned cycle -> grant drops with timeout=0.
- Reset asserted mid-ownership (grant=1000, bus_out=0x77); HOLD=0 variant ends a grant -> after the Reset edge grant=0000, bus_out=0x00, rr_ptr=0, and next grant with req=1001 goes to channel 0. In the HOLD=0 variant, bus_out=0x00 on the idle cycle. Dropping req[k] mid-ownership also ends the grant one cycle later.
